// File: rtl/mem_arbiter_if.sv
// Bundle of the instruction-cache, data-cache and physical-memory signals around mem_arbiter.
// The slave modport is the arbiter's view; master is the surrounding caches and memory.
interface mem_arbiter_if #(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
);
  logic              i_mem_read;
  logic [ADDR_W-1:0] i_mem_address;
  logic [LINE_W-1:0] i_mem_rdata;
  logic              i_mem_resp;

  logic              d_mem_read;
  logic              d_mem_write;
  logic [ADDR_W-1:0] d_mem_address;
  logic [LINE_W-1:0] d_mem_wdata;
  logic [LINE_W-1:0] d_mem_rdata;
  logic              d_mem_resp;

  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  modport slave (
    input  i_mem_read, i_mem_address,
    output i_mem_rdata, i_mem_resp,
    input  d_mem_read, d_mem_write, d_mem_address, d_mem_wdata,
    output d_mem_rdata, d_mem_resp,
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_rdata, pmem_resp
  );

  modport master (
    output i_mem_read, i_mem_address,
    input  i_mem_rdata, i_mem_resp,
    output d_mem_read, d_mem_write, d_mem_address, d_mem_wdata,
    input  d_mem_rdata, d_mem_resp,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_rdata, pmem_resp
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates I-cache fills and D-cache fills/writebacks onto one physical memory port.
// Define ARB_ROUND_ROBIN_EN to alternate tie winners; otherwise the data side wins every tie.
module mem_arbiter #(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SERVE_I = 2'd1;
  localparam logic [1:0] SERVE_D = 2'd2;
  localparam logic [1:0] RECOVER = 2'd3;

  logic [1:0]        state_q, state_d;
  logic              pmem_read_q, pmem_read_d;
  logic              pmem_write_q, pmem_write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic              i_req;
  logic              d_req;
  logic              pick_data;
`ifdef ARB_ROUND_ROBIN_EN
  // High when the most recent grant went to the data side.
  logic              last_data_q, last_data_d;
`endif

  assign i_req = bus.i_mem_read;
  assign d_req = bus.d_mem_read | bus.d_mem_write;

`ifdef ARB_ROUND_ROBIN_EN
  assign pick_data = d_req & (~i_req | ~last_data_q);
`else
  assign pick_data = d_req;
`endif

  always_comb begin
    state_d      = state_q;
    pmem_read_d  = pmem_read_q;
    pmem_write_d = pmem_write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_data_d  = last_data_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_data) begin
          state_d      = SERVE_D;
          pmem_read_d  = ~bus.d_mem_write;
          pmem_write_d = bus.d_mem_write;
          addr_d       = bus.d_mem_address;
          wdata_d      = bus.d_mem_wdata;
`ifdef ARB_ROUND_ROBIN_EN
          last_data_d  = 1'b1;
`endif
        end else if (i_req) begin
          state_d      = SERVE_I;
          pmem_read_d  = 1'b1;
          pmem_write_d = 1'b0;
          addr_d       = bus.i_mem_address;
          wdata_d      = '0;
`ifdef ARB_ROUND_ROBIN_EN
          last_data_d  = 1'b0;
`endif
        end
      end
      SERVE_I, SERVE_D: begin
        // The command is held until memory completes, regardless of the requester.
        if (bus.pmem_resp) begin
          state_d      = RECOVER;
          pmem_read_d  = 1'b0;
          pmem_write_d = 1'b0;
          addr_d       = '0;
          wdata_d      = '0;
        end
      end
      RECOVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pmem_read_q  <= 1'b0;
      pmem_write_q <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_data_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      pmem_read_q  <= pmem_read_d;
      pmem_write_q <= pmem_write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_data_q  <= last_data_d;
`endif
    end
  end

  assign bus.pmem_read    = pmem_read_q;
  assign bus.pmem_write   = pmem_write_q;
  assign bus.pmem_address = addr_q;
  assign bus.pmem_wdata   = wdata_q;

  // Completion is forwarded in the same cycle, only to the side that owns the transaction.
  assign bus.i_mem_resp  = (state_q == SERVE_I) & bus.pmem_resp;
  assign bus.d_mem_resp  = (state_q == SERVE_D) & bus.pmem_resp;
  assign bus.i_mem_rdata = bus.i_mem_resp ? bus.pmem_rdata : '0;
  assign bus.d_mem_rdata = bus.d_mem_resp ? bus.pmem_rdata : '0;

endmodule
